// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the lcd24x3 page scheduler.
package lcd_pkg;
    localparam int CHAR_W = 5;
    localparam int DIGITS = 8;
    localparam int ROW_W  = CHAR_W * DIGITS;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'h1F;
    localparam logic [ROW_W-1:0]  ROW_BLANK  = {DIGITS{CHAR_BLANK}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } state_t;
endpackage

// File: rtl/lcd_ms_tick.sv
// Free-running Fclk prescaler; oTick is high for one clk per millisecond.
module lcd_ms_tick #(
    parameter int Fclk = 10000
) (
    input  logic clk,
    input  logic iRst,
    output logic oTick
);
    localparam int              PW   = (Fclk > 1) ? $clog2(Fclk) : 1;
    localparam logic [PW-1:0]   LAST = PW'(Fclk - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign oTick = (cnt_q == LAST);
endmodule

// File: rtl/lcd_page_scheduler.sv
// Multiplexes NPages character pages onto one 8-digit lcd24x3: timed rotation,
// manual advance/hold, and a blinking alert page that preempts rotation.
module lcd_page_scheduler
    import lcd_pkg::*;
#(
    parameter int Fclk    = 10000,
    parameter int NPages  = 4,
    parameter int DwellMs = 2000,
    parameter int BlinkMs = 250
) (
    input  logic                      clk,
    input  logic                      iRst,
    input  logic [NPages*40-1:0]      iPageData,
    input  logic [NPages*8-1:0]       iPagePoint,
    input  logic [NPages-1:0]         iPageEn,
    input  logic [NPages-1:0]         iAlertReq,
    input  logic                      iNext,
    input  logic                      iHold,
    output logic [39:0]               oChar,
    output logic [7:0]                oPoint,
    output logic [$clog2(NPages)-1:0] oPage,
    output logic                      oAlert,
    output logic                      oBlank
);
    localparam int PGW = $clog2(NPages);
    localparam int DW  = (DwellMs > 1) ? $clog2(DwellMs) : 1;
    localparam int BW  = (BlinkMs > 1) ? $clog2(BlinkMs) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DwellMs - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BlinkMs - 1);

    // Circular search starting after c; falls back to c itself. MSB = found.
    function automatic logic [PGW:0] next_en(input logic [PGW-1:0] c,
                                             input logic [NPages-1:0] en);
        logic [PGW:0] r;
        int           idx;
        r = '0;
        for (int i = NPages - 1; i >= 1; i--) begin
            idx = (int'(c) + i) % NPages;
            if (en[PGW'(idx)]) r = {1'b1, PGW'(idx)};
        end
        if (!r[PGW] && en[c]) r = {1'b1, c};
        return r;
    endfunction

    function automatic logic [PGW-1:0] lowest_set(input logic [NPages-1:0] v);
        logic [PGW-1:0] r;
        r = '0;
        for (int i = NPages - 1; i >= 0; i--) begin
            if (v[i]) r = PGW'(i);
        end
        return r;
    endfunction

    logic [ROW_W-1:0] page_row [NPages];
    logic [7:0]       page_pt  [NPages];

    for (genvar p = 0; p < NPages; p++) begin : g_unpack
        assign page_row[p] = iPageData[p*ROW_W +: ROW_W];
        assign page_pt[p]  = iPagePoint[p*8 +: 8];
    end

    logic ms_tick;

    lcd_ms_tick #(.Fclk(Fclk)) u_ms_tick (
        .clk   (clk),
        .iRst  (iRst),
        .oTick (ms_tick)
    );

    state_t           state_q, state_d;
    logic [PGW-1:0]   page_q, page_d;
    logic [PGW-1:0]   ret_q, ret_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [BW-1:0]    blink_q, blink_d;
    logic             phase_q, phase_d;
    logic [ROW_W-1:0] char_q, char_d;
    logic [7:0]       point_q, point_d;
    logic             alert_q, alert_d;
    logic             blank_q, blank_d;

    logic [PGW:0]     nxt;
    logic [PGW:0]     ret_nxt;
    logic             show_data;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        ret_d   = ret_q;
        dwell_d = dwell_q;
        blink_d = blink_q;
        phase_d = phase_q;
        nxt     = next_en(page_q, iPageEn);
        ret_nxt = next_en(ret_q, iPageEn);

        case (state_q)
            IDLE, SHOW: begin
                if (|iAlertReq) begin
                    state_d = ALERT;
                    ret_d   = page_q;
                    page_d  = lowest_set(iAlertReq);
                    blink_d = '0;
                    phase_d = 1'b1;
                end else if (state_q == IDLE) begin
                    if (|iPageEn) begin
                        state_d = SHOW;
                        page_d  = lowest_set(iPageEn);
                        dwell_d = '0;
                    end
                end else if (!iPageEn[page_q]) begin
                    if (nxt[PGW]) begin
                        page_d  = nxt[PGW-1:0];
                        dwell_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (iNext || (ms_tick && !iHold && dwell_q == DWELL_LAST)) begin
                    // Current page is enabled, so the search always finds something.
                    page_d  = nxt[PGW-1:0];
                    dwell_d = '0;
                end else if (ms_tick && !iHold) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ALERT: begin
                if (|iAlertReq) begin
                    page_d = lowest_set(iAlertReq);
                    if (ms_tick) begin
                        if (blink_q == BLINK_LAST) begin
                            blink_d = '0;
                            phase_d = ~phase_q;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end else begin
                    dwell_d = '0;
                    if (iPageEn[ret_q]) begin
                        state_d = SHOW;
                        page_d  = ret_q;
                    end else if (ret_nxt[PGW]) begin
                        state_d = SHOW;
                        page_d  = ret_nxt[PGW-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state and the live data of the next page.
        show_data = (state_d == SHOW) || (state_d == ALERT && phase_d);
        char_d    = show_data ? page_row[page_d] : ROW_BLANK;
        point_d   = show_data ? page_pt[page_d] : 8'h00;
        blank_d   = !show_data;
        alert_d   = (state_d == ALERT);
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            page_q  <= '0;
            ret_q   <= '0;
            dwell_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            char_q  <= ROW_BLANK;
            point_q <= 8'h00;
            alert_q <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            ret_q   <= ret_d;
            dwell_q <= dwell_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            char_q  <= char_d;
            point_q <= point_d;
            alert_q <= alert_d;
            blank_q <= blank_d;
        end
    end

    assign oChar  = char_q;
    assign oPoint = point_q;
    assign oPage  = page_q;
    assign oAlert = alert_q;
    assign oBlank = blank_q;
endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Scoreboard bench for lcd_page_scheduler with 1 ms = 10 clk, dwell 3 ms, blink 2 ms.
module tb_lcd_page_scheduler;
    localparam logic [39:0] BLANK = {8{5'h1F}};

    logic               clk;
    logic               iRst;
    logic [159:0]       iPageData;
    logic [31:0]        iPagePoint;
    logic [3:0]         iPageEn;
    logic [3:0]         iAlertReq;
    logic               iNext;
    logic               iHold;
    logic [39:0]        oChar;
    logic [7:0]         oPoint;
    logic [1:0]         oPage;
    logic               oAlert;
    logic               oBlank;

    lcd_page_scheduler #(
        .Fclk(10), .NPages(4), .DwellMs(3), .BlinkMs(2)
    ) dut (
        .clk        (clk),
        .iRst       (iRst),
        .iPageData  (iPageData),
        .iPagePoint (iPagePoint),
        .iPageEn    (iPageEn),
        .iAlertReq  (iAlertReq),
        .iNext      (iNext),
        .iHold      (iHold),
        .oChar      (oChar),
        .oPoint     (oPoint),
        .oPage      (oPage),
        .oAlert     (oAlert),
        .oBlank     (oBlank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [39:0] ch;
        logic [7:0]  pt;
        logic [1:0]  pg;
        logic        al;
        logic        bl;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [39:0] pdata [4];
    logic [7:0]  ppt   [4];

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic drive_pages();
        for (int p = 0; p < 4; p++) begin
            iPageData[p*40 +: 40] = pdata[p];
            iPagePoint[p*8 +: 8]  = ppt[p];
        end
    endtask

    task automatic push_exp(input string tag, input logic [39:0] ch, input logic [7:0] pt,
                            input logic [1:0] pg, input logic al, input logic bl);
        exp_t e;
        e.tag = tag; e.ch = ch; e.pt = pt; e.pg = pg; e.al = al; e.bl = bl;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, ".char"},  oChar,  e.ch);
            check_eq({e.tag, ".point"}, {32'h0, oPoint}, {32'h0, e.pt});
            check_eq({e.tag, ".page"},  {38'h0, oPage},  {38'h0, e.pg});
            check_eq({e.tag, ".alert"}, {39'h0, oAlert}, {39'h0, e.al});
            check_eq({e.tag, ".blank"}, {39'h0, oBlank}, {39'h0, e.bl});
        end
    endtask

    // Push the expectation, clock one edge, then compare what the DUT produced.
    task automatic step_expect(input string tag, input logic [39:0] ch, input logic [7:0] pt,
                               input logic [1:0] pg, input logic al, input logic bl);
        push_exp(tag, ch, pt, pg, al, bl);
        tick();
        compare_front();
    endtask

    task automatic show(input string tag, input int p);
        step_expect(tag, pdata[p], ppt[p], 2'(p), 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            pdata[0][5*k +: 5] = 5'(k);
            pdata[1][5*k +: 5] = 5'(16 + k);
            pdata[2][5*k +: 5] = 5'(8 + k);
            pdata[3][5*k +: 5] = 5'(30 - k);
        end
        ppt[0] = 8'h01; ppt[1] = 8'h22; ppt[2] = 8'h04; ppt[3] = 8'h88;
        iRst = 1'b1; iPageEn = '0; iAlertReq = '0; iNext = 1'b0; iHold = 1'b0;
        iPageData = '0; iPagePoint = '0;
        drive_pages();

        tick();
        push_exp("reset", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);
        compare_front();
        iRst = 1'b0;
        cyc  = 0;

        // Idle with nothing enabled.
        step_expect("idle_first", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);
        run_to(99);
        step_expect("idle_100", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);

        // Rotation 0 -> 2 -> 0 every 30 clk; entry at edge 101.
        iPageEn = 4'b0101;
        show("enter_show", 0);
        run_to(128);
        show("dwell_end_p0", 0);
        show("rotate_to_p2", 2);
        run_to(158);
        show("dwell_end_p2", 2);
        show("rotate_to_p0", 0);

        // Hold freezes dwell; iNext still advances and restarts dwell.
        iHold = 1'b1;
        run_to(189);
        show("hold_190", 0);
        run_to(205);
        iNext = 1'b1;
        show("next_in_hold", 2);
        iNext = 1'b0;
        run_to(219);
        show("hold_220", 2);
        iHold = 1'b0;
        run_to(248);
        show("after_hold_249", 2);
        show("after_hold_250", 0);

        // Alert on page 3, blinking with a 20 clk half-period.
        run_to(255);
        iAlertReq = 4'b1000;
        step_expect("alert_enter", pdata[3], ppt[3], 2'd3, 1'b1, 1'b0);
        run_to(268);
        step_expect("blink_on_269", pdata[3], ppt[3], 2'd3, 1'b1, 1'b0);
        step_expect("blink_off_270", BLANK, 8'h00, 2'd3, 1'b1, 1'b1);
        run_to(288);
        step_expect("blink_off_289", BLANK, 8'h00, 2'd3, 1'b1, 1'b1);
        step_expect("blink_on_290", pdata[3], ppt[3], 2'd3, 1'b1, 1'b0);
        run_to(295);
        iAlertReq = 4'b1010;
        iNext = 1'b1;
        step_expect("alert_switch", pdata[1], ppt[1], 2'd1, 1'b1, 1'b0);
        iNext = 1'b0;
        run_to(309);
        step_expect("blink_off_310", BLANK, 8'h00, 2'd1, 1'b1, 1'b1);
        run_to(315);
        iAlertReq = 4'b0000;
        show("alert_release", 0);

        // Page-disable handling.
        run_to(339);
        show("rotate_340", 2);
        run_to(345);
        iPageEn = 4'b0001;
        show("drop_cur_page", 0);
        run_to(350);
        iPageEn = 4'b0000;
        step_expect("drop_all", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);
        run_to(359);
        step_expect("idle_again", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of an alert.
        iPageEn = 4'b0101;
        show("reenable", 0);
        run_to(365);
        iAlertReq = 4'b0100;
        step_expect("alert_p2", pdata[2], ppt[2], 2'd2, 1'b1, 1'b0);
        run_to(370);
        #2;
        iRst = 1'b1;
        #1;
        push_exp("async_reset", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);
        compare_front();
        iAlertReq = 4'b0000;
        step_expect("reset_held", BLANK, 8'h00, 2'd0, 1'b0, 1'b1);
        iRst = 1'b0;
        cyc  = 0;

        // Expiry and iNext on the same edge give one advance.
        show("post_reset", 0);
        run_to(29);
        iNext = 1'b1;
        show("expiry_plus_next", 2);
        iNext = 1'b0;
        run_to(59);
        show("rotate_60", 0);

        // Live data reaches the outputs one edge after it changes.
        run_to(65);
        pdata[0] = {8{5'h0A}};
        ppt[0]   = 8'hF0;
        drive_pages();
        show("live_data", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_page_scheduler.md
Name: lcd_page_scheduler

Overview:
- Shares the single 8-digit lcd24x3 display among NPages requesters ("pages"), each supplying 8 five-bit character codes plus 8 decimal points.
- Rotates through the enabled pages on a millisecond dwell timer, and supports manual advance and hold.
- Any alert request preempts rotation and shows the alert page blinking.
- Sits between the application logic and lcd24x3; its outputs drive iChar7..iChar0 and iPoint directly.

Parameters:
- Fclk, 10000, clk frequency in kHz; the 1 ms prescaler counts Fclk cycles.
- NPages, 4, number of requesters (2..8).
- DwellMs, 2000, display time per page in ms (>=1).
- BlinkMs, 250, alert blink half-period in ms (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- iRst  in  1  asynchronous, active-high reset.
- iPageData  in  NPages*40  page p chars at [p*40+39:p*40]; char k at bits [p*40+5k+4 : p*40+5k], with char 7 leftmost.
- iPagePoint  in  NPages*8  page p decimal points at [p*8+7:p*8].
- iPageEn  in  NPages  page p participates in rotation.
- iAlertReq  in  NPages  level; page p demands alert display.
- iNext  in  1  single-cycle pulse; advance to the next enabled page.
- iHold  in  1  level; freezes the dwell counter.
- oChar  out  40  chars to the LCD, same packing as one page.
- oPoint  out  8  points to the LCD.
- oPage  out  $clog2(NPages)  index of the page currently selected.
- oAlert  out  1  high while in ALERT.
- oBlank  out  1  high while the outputs are forced blank.

Behaviour:
- Reset (async, immediate): state=IDLE, oChar=all CHAR_BLANK, oPoint=0, oPage=0, oAlert=0, oBlank=1; prescaler, dwell and blink counters cleared; blink phase=ON.
- Tick: prescaler counts 0..Fclk-1 and pulses msTick for one cycle at Fclk-1. The prescaler runs freely in every state.
- All outputs are registered. Outputs reflect the next state/page and the live page data on the same clock edge the state updates, so any input change reaches the outputs after exactly one edge.
- nextEn(c): circular search c+1, c+2, … returning the first enabled index. If none is found other than c, it returns c if c is enabled; otherwise it returns "none".

IDLE:
- Outputs are blank; oBlank=1.
- If any iPageEn bit is set: go to SHOW with page = lowest enabled index, dwell=0.

SHOW:
- oChar/oPoint = selected page data; oBlank=0.
- Dwell increments on msTick unless iHold=1.
- Advance when (msTick and dwell==DwellMs-1 and !iHold) or iNext:
  - page=nextEn(page), dwell=0.
  - If the result is the same page, only dwell resets.
- Simultaneous expiry and iNext produce a single advance.
- If the current page's iPageEn drops: advance to nextEn on the next edge; if none is enabled, go to IDLE.

ALERT (entered from IDLE or SHOW whenever iAlertReq≠0):
- Save the current page as retPage.
- page = lowest set index in iAlertReq, independent of iPageEn.
- blink counter=0, phase=ON; oAlert=1.
- Phase toggles every BlinkMs ms.
  - ON: shows page data, oBlank=0.
  - OFF: chars CHAR_BLANK, points 0, oBlank=1.
- A lower-index alert asserting mid-alert switches page immediately; blink timing continues uninterrupted.
- iNext and iHold are ignored.
- When iAlertReq==0: return to SHOW at retPage if it is enabled; otherwise nextEn(retPage); if none, go to IDLE. dwell=0, oAlert=0.

Priority per edge: iRst > alert entry/update > page-disable > advance > dwell count.

Width rules:
- dwell and blink counters are wide enough for DwellMs-1 and BlinkMs-1.
- The prescaler is $clog2(Fclk) wide.
- No counter overflows, because each is compared and cleared before it wraps.

Decomposition:
- Shared package lcd_pkg holds:
  - CHAR_W=5
  - DIGITS=8
  - CHAR_BLANK=5'h1F (the lcd24x3 blank code)
  - state encoding IDLE/SHOW/ALERT
- One sub-module, lcd_ms_tick, contains the parameterised Fclk prescaler that produces msTick.
- The circular priority search stays as a function inside lcd_page_scheduler.

Test Plan (Fclk=10, DwellMs=3, BlinkMs=2, NPages=4; 1 ms = 10 clk):
- Reset with iPageEn=0 -> oChar all 5'h1F, oBlank=1, oPage=0; stays IDLE for 100 cycles.
- iPageEn=4'b0101, page0 chars 0..7, page2 chars 8..F -> oPage 0 → 2 → 0, changing every 30 cycles; oChar tracks the selected page one edge after each change.
- iHold=1 for 60 cycles while in SHOW -> oPage constant; iNext pulse during the hold -> oPage advances one edge later and dwell restarts.
- iAlertReq=4'b1000 while showing page0 -> next edge oPage=3, oAlert=1. oChar alternates page3 data/blank every 20 cycles. iAlertReq=4'b1010 -> oPage=1. Alert release -> oPage=0, oAlert=0.
- Drop iPageEn[2] while page2 is shown with only page0 otherwise enabled -> oPage=0 next edge. Drop all iPageEn -> IDLE, blank.
- Assert iRst mid-ALERT between clock edges -> outputs take reset values immediately, without waiting for clk.
